// File: rtl/game_pkg.sv
// Shared board geometry, FSM state encoding and tile helpers for the sequencer
// and the player controller.
package game_pkg;

  localparam logic [9:0] START_X      = 10'd20;
  localparam logic [9:0] TILE_SPACING = 10'd60;
  localparam logic [9:0] FLAG_X       = 10'd620;
  localparam logic [3:0] LAST_TILE    = 4'd10;

  typedef logic [2:0] state_t;

  localparam state_t IDLE       = 3'd0;
  localparam state_t ISSUE      = 3'd1;
  localparam state_t WAIT_DONE  = 3'd2;
  localparam state_t ADVANCE    = 3'd3;
  localparam state_t RESTART_P1 = 3'd4;
  localparam state_t RESTART_P2 = 3'd5;
  localparam state_t GAME_OVER  = 3'd6;

  function automatic logic [9:0] tile_to_x(input logic [3:0] tile);
    return START_X + TILE_SPACING * {6'd0, tile};
  endfunction

  // 9 + 6 = 15 still fits in 4 bits, so the clamp needs no wider sum.
  function automatic logic [3:0] next_tile(input logic [3:0] tile, input logic [2:0] roll);
    logic [3:0] sum;
    sum = tile + {1'b0, roll};
    return (sum > LAST_TILE) ? LAST_TILE : sum;
  endfunction

endpackage

// File: rtl/turn_sequencer.sv
// Two-player board-game turn sequencer: accepts die rolls, issues moves to the
// player controller, tracks tiles, detects the winner and handles restarts.
module turn_sequencer
  import game_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       roll_valid,
  input  logic [2:0] roll_value,
  input  logic       new_game,
  input  logic       player1_turn_done,
  input  logic       player2_turn_done,
  output logic [9:0] player1_target_x,
  output logic [9:0] player2_target_x,
  output logic       player1_move_start,
  output logic       player2_move_start,
  output logic       active_player,
  output logic [3:0] p1_tile,
  output logic [3:0] p2_tile,
  output logic       busy,
  output logic       game_over,
  output logic       winner,
  output logic       roll_error,
  output logic       timeout_err
);

  localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);

  state_t        state;
  logic [3:0]    target_tile;
  logic          restart_wait;
  logic [CW-1:0] timer;

  logic [3:0] cur_tile;
  logic [3:0] next_t;
  logic       roll_legal;
  logic       own_done;
  logic       timer_expired;

  always_comb begin
    cur_tile      = active_player ? p2_tile : p1_tile;
    next_t        = next_tile(cur_tile, roll_value);
    roll_legal    = (roll_value != 3'd0) && (roll_value != 3'd7);
    own_done      = active_player ? player2_turn_done : player1_turn_done;
    timer_expired = (timer == CW'(TIMEOUT_CYCLES - 1));
    busy          = (state != IDLE) && (state != GAME_OVER);
    game_over     = (state == GAME_OVER);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state              <= IDLE;
      target_tile        <= '0;
      restart_wait       <= 1'b0;
      timer              <= '0;
      player1_target_x   <= START_X;
      player2_target_x   <= START_X;
      player1_move_start <= 1'b0;
      player2_move_start <= 1'b0;
      active_player      <= 1'b0;
      p1_tile            <= '0;
      p2_tile            <= '0;
      winner             <= 1'b0;
      roll_error         <= 1'b0;
      timeout_err        <= 1'b0;
    end else begin
      player1_move_start <= 1'b0;
      player2_move_start <= 1'b0;
      roll_error         <= 1'b0;
      timeout_err        <= 1'b0;
      case (state)
        IDLE: begin
          if (new_game) begin
            player1_target_x   <= START_X;
            player1_move_start <= 1'b1;
            restart_wait       <= 1'b0;
            state              <= RESTART_P1;
          end else if (roll_valid) begin
            if (roll_legal) begin
              target_tile <= next_t;
              if (active_player) begin
                player2_target_x   <= tile_to_x(next_t);
                player2_move_start <= 1'b1;
              end else begin
                player1_target_x   <= tile_to_x(next_t);
                player1_move_start <= 1'b1;
              end
              state <= ISSUE;
            end else begin
              roll_error <= 1'b1;
            end
          end
        end
        ISSUE: begin
          timer <= '0;
          state <= WAIT_DONE;
        end
        WAIT_DONE: begin
          if (own_done || timer_expired) begin
            timeout_err <= ~own_done;
            if (active_player) p2_tile <= target_tile;
            else               p1_tile <= target_tile;
            state <= ADVANCE;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        ADVANCE: begin
          if (target_tile == LAST_TILE) begin
            winner <= active_player;
            state  <= GAME_OVER;
          end else begin
            active_player <= ~active_player;
            state         <= IDLE;
          end
        end
        // Restart states spend their first cycle on the move_start pulse,
        // then wait on turn_done with the shared timeout counter.
        RESTART_P1: begin
          if (!restart_wait) begin
            restart_wait <= 1'b1;
            timer        <= '0;
          end else if (player1_turn_done || timer_expired) begin
            timeout_err        <= ~player1_turn_done;
            p1_tile            <= '0;
            player2_target_x   <= START_X;
            player2_move_start <= 1'b1;
            restart_wait       <= 1'b0;
            state              <= RESTART_P2;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        RESTART_P2: begin
          if (!restart_wait) begin
            restart_wait <= 1'b1;
            timer        <= '0;
          end else if (player2_turn_done || timer_expired) begin
            timeout_err   <= ~player2_turn_done;
            p2_tile       <= '0;
            active_player <= 1'b0;
            restart_wait  <= 1'b0;
            state         <= IDLE;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        GAME_OVER: begin
          if (new_game) begin
            player1_target_x   <= START_X;
            player1_move_start <= 1'b1;
            restart_wait       <= 1'b0;
            state              <= RESTART_P1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_turn_sequencer.sv
// Self-checking bench for turn_sequencer: directed game scenarios plus a
// randomized game, compared against a tile/turn reference model.
module tb_turn_sequencer;

  localparam int unsigned T = 16;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       roll_valid = 1'b0;
  logic [2:0] roll_value = 3'd0;
  logic       new_game = 1'b0;
  logic       p1_done = 1'b0;
  logic       p2_done = 1'b0;
  logic [9:0] p1_x, p2_x;
  logic       p1_start, p2_start, active_player;
  logic [3:0] p1_tile, p2_tile;
  logic       busy, game_over, winner, roll_error, timeout_err;

  turn_sequencer #(.TIMEOUT_CYCLES(T)) dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .roll_valid         (roll_valid),
    .roll_value         (roll_value),
    .new_game           (new_game),
    .player1_turn_done  (p1_done),
    .player2_turn_done  (p2_done),
    .player1_target_x   (p1_x),
    .player2_target_x   (p2_x),
    .player1_move_start (p1_start),
    .player2_move_start (p2_start),
    .active_player      (active_player),
    .p1_tile            (p1_tile),
    .p2_tile            (p2_tile),
    .busy               (busy),
    .game_over          (game_over),
    .winner             (winner),
    .roll_error         (roll_error),
    .timeout_err        (timeout_err)
  );

  always #5 clk = ~clk;

  int passes = 0;
  int total  = 0;
  int m_tile[2];
  int m_active;
  bit m_over;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) passes++;
    else $error("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int tx(input int tile);
    return 20 + 60 * tile;
  endfunction

  task automatic model_reset();
    m_tile[0] = 0;
    m_tile[1] = 0;
    m_active  = 0;
    m_over    = 0;
  endtask

  task automatic check_state(input string tag);
    check({tag, ".p1_tile"}, p1_tile, m_tile[0]);
    check({tag, ".p2_tile"}, p2_tile, m_tile[1]);
    check({tag, ".active"}, active_player, m_active);
    check({tag, ".game_over"}, game_over, m_over);
    check({tag, ".busy"}, busy, 0);
  endtask

  task automatic check_reset(input string tag);
    check({tag, ".p1_x"}, p1_x, 20);
    check({tag, ".p2_x"}, p2_x, 20);
    check({tag, ".starts"}, {p1_start, p2_start}, 0);
    check({tag, ".winner"}, winner, 0);
    check({tag, ".errs"}, {roll_error, timeout_err}, 0);
    check_state(tag);
  endtask

  task automatic play(input int roll, input bit use_timeout, input bit noise);
    int who, tgt, n;
    bit seen;
    who = m_active;
    tgt = m_tile[who] + roll;
    if (tgt > 10) tgt = 10;
    roll_valid = 1'b1;
    roll_value = 3'(roll);
    tick();
    roll_valid = 1'b0;
    check("move_start", who ? p2_start : p1_start, 1);
    check("other_start", who ? p1_start : p2_start, 0);
    check("target_x", who ? p2_x : p1_x, tx(tgt));
    check("busy_issue", busy, 1);
    tick();
    check("start_low", {p1_start, p2_start}, 0);
    n = 0;
    if (noise) begin
      roll_valid = 1'b1;
      roll_value = 3'($urandom_range(1, 6));
      if (who == 0) p2_done = 1'b1;
      else          p1_done = 1'b1;
      tick();
      roll_valid = 1'b0;
      p1_done = 1'b0;
      p2_done = 1'b0;
      n = 1;
      check("noise_ignored", {p1_start, p2_start, roll_error, timeout_err}, 0);
      check("noise_tile", who ? p2_tile : p1_tile, m_tile[who]);
    end
    if (use_timeout) begin
      seen = 0;
      while (!seen && n < int'(T) + 4) begin
        tick();
        n++;
        seen = timeout_err;
      end
      check("timeout_at", n, T);
    end else begin
      repeat ($urandom_range(0, 3)) tick();
      if (who == 0) p1_done = 1'b1;
      else          p2_done = 1'b1;
      tick();
      p1_done = 1'b0;
      p2_done = 1'b0;
      check("no_timeout", timeout_err, 0);
    end
    m_tile[who] = tgt;
    check("tile_commit", who ? p2_tile : p1_tile, tgt);
    tick();
    if (tgt == 10) begin
      m_over = 1;
      check("winner", winner, who);
    end else begin
      m_active = 1 - m_active;
    end
    check_state("after_turn");
  endtask

  task automatic illegal(input int val);
    roll_valid = 1'b1;
    roll_value = 3'(val);
    tick();
    roll_valid = 1'b0;
    check("roll_error", roll_error, 1);
    check("illegal_no_start", {p1_start, p2_start}, 0);
    tick();
    check("roll_error_pulse", roll_error, 0);
    check_state("after_illegal");
  endtask

  task automatic restart(input bit with_roll);
    new_game = 1'b1;
    if (with_roll) begin
      roll_valid = 1'b1;
      roll_value = 3'd3;
    end
    tick();
    new_game = 1'b0;
    roll_valid = 1'b0;
    check("rs_p1_start", p1_start, 1);
    check("rs_p1_x", p1_x, 20);
    check("rs_p2_start0", p2_start, 0);
    check("rs_busy", busy, 1);
    check("rs_no_err", roll_error, 0);
    tick();
    check("rs_p1_low", p1_start, 0);
    repeat ($urandom_range(0, 3)) tick();
    p1_done = 1'b1;
    tick();
    p1_done = 1'b0;
    check("rs_p2_start", p2_start, 1);
    check("rs_p2_x", p2_x, 20);
    check("rs_p1_quiet", p1_start, 0);
    tick();
    check("rs_p2_low", p2_start, 0);
    p2_done = 1'b1;
    tick();
    p2_done = 1'b0;
    model_reset();
    check_state("after_restart");
  endtask

  initial begin
    int turns;
    model_reset();
    repeat (2) tick();
    check_reset("reset");
    rst_n = 1'b1;
    tick();

    play(3, 0, 0);
    play(1, 0, 1);
    illegal(0);
    illegal(7);
    play(5, 0, 0);
    play(1, 0, 0);
    play(6, 0, 0);

    roll_valid = 1'b1;
    roll_value = 3'd4;
    tick();
    roll_valid = 1'b0;
    check("over_no_start", {p1_start, p2_start, roll_error}, 0);
    tick();
    check_state("over_hold");

    restart(0);
    play(2, 1, 1);

    turns = 0;
    while (!m_over && turns < 60) begin
      if ($urandom_range(0, 4) == 0) illegal($urandom_range(0, 1) ? 0 : 7);
      play($urandom_range(1, 6), $urandom_range(0, 5) == 0, 1'($urandom_range(0, 1)));
      turns++;
    end
    check("random_game_ends", m_over, 1);

    restart(0);
    restart(1);
    play(4, 0, 0);

    roll_valid = 1'b1;
    roll_value = 3'd5;
    tick();
    roll_valid = 1'b0;
    tick();
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    check_reset("midturn_reset");
    repeat (2) tick();
    rst_n = 1'b1;
    repeat (3) begin
      tick();
      check("release_no_start", {p1_start, p2_start}, 0);
    end
    play(2, 0, 0);

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule
